// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU and its iterative divider.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } mext_e;

    typedef enum logic [1:0] {
        DV_IDLE = 2'd0,
        DV_RUN  = 2'd1,
        DV_FIX  = 2'd2
    } div_phase_e;

    // Special-case results, sliced to XLEN by the users.
    localparam logic [63:0] DIV0_QUOT = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] OVF_REM   = 64'h0000_0000_0000_0000;

endpackage

// File: rtl/alu_div.sv
// Radix-2 restoring divider: XLEN iteration cycles, then one sign-fixup cycle
// during which done is high and quot/rem are valid.
module alu_div
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            signed_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);
    localparam int CW = $clog2(XLEN) + 1;

    div_phase_e      phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d, dvd_q, dvd_d;
    logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d, div0_q, div0_d, ovf_q, ovf_d;
    logic            a_neg_s, b_neg_s;
    logic [XLEN:0]   rem_sh_s, trial_s;

    // Iteration control and one restoring step per cycle.
    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        dvd_d    = dvd_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        a_neg_s  = signed_op & dividend[XLEN-1];
        b_neg_s  = signed_op & divisor[XLEN-1];
        rem_sh_s = {rem_q, quot_q[XLEN-1]};
        trial_s  = rem_sh_s - {1'b0, dvs_q};
        case (phase_q)
            DV_IDLE: begin
                if (start) begin
                    phase_d = DV_RUN;
                    cnt_d   = {CW{1'b0}};
                    quot_d  = a_neg_s ? (-dividend) : dividend;
                    rem_d   = {XLEN{1'b0}};
                    dvs_d   = b_neg_s ? (-divisor) : divisor;
                    dvd_d   = dividend;
                    q_neg_d = a_neg_s ^ b_neg_s;
                    r_neg_d = a_neg_s;
                    div0_d  = (divisor == {XLEN{1'b0}});
                    ovf_d   = signed_op && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                              && (divisor == {XLEN{1'b1}});
                end else begin
                    phase_d = DV_IDLE;
                end
            end
            DV_RUN: begin
                if (!trial_s[XLEN]) begin
                    rem_d  = trial_s[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh_s[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == CW'(XLEN-1)) begin
                    phase_d = DV_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DV_FIX:  phase_d = DV_IDLE;
            default: phase_d = DV_IDLE;
        endcase
    end

    // Sign fixup and the architecturally defined special cases.
    always_comb begin
        done = (phase_q == DV_FIX);
        quot = {XLEN{1'b0}};
        rem  = {XLEN{1'b0}};
        if (phase_q == DV_FIX) begin
            if (div0_q) begin
                quot = DIV0_QUOT[XLEN-1:0];
                rem  = dvd_q;
            end else if (ovf_q) begin
                quot = dvd_q;
                rem  = OVF_REM[XLEN-1:0];
            end else begin
                quot = q_neg_q ? (-quot_q) : quot_q;
                rem  = r_neg_q ? (-rem_q) : rem_q;
            end
        end else begin
            done = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= DV_IDLE;
            cnt_q   <= {CW{1'b0}};
            quot_q  <= {XLEN{1'b0}};
            rem_q   <= {XLEN{1'b0}};
            dvs_q   <= {XLEN{1'b0}};
            dvd_q   <= {XLEN{1'b0}};
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV32I/RV64I ALU with valid/ready handshake and registered result/flags.
// Define ALU_M_EXT_EN to build the M-extension multiplier and divider.
module alu_mc
    import alu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    input  logic [1:0]      funct7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            z,
    output logic            n,
    output logic            c,
    output logic            v,
    output logic            illegal,
    output logic            busy
);
    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] rd_q, rd_d, base_res_s, b_op_s, sra_s;
    logic            z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, ill_q, ill_d;
    logic            accept_s, base_c_s, base_v_s;
    logic [XLEN:0]   sum_s;
    logic [SHW-1:0]  shamt_s;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign rd        = rd_q;
    assign z         = z_q;
    assign n         = n_q;
    assign c         = c_q;
    assign v         = v_q;
    assign illegal   = ill_q;

`ifdef ALU_M_EXT_EN
    logic [XLEN-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [1:0]        mop_q, mop_d;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   mul_res_s, div_quot_s, div_rem_s, div_res_s;
    logic              a_sgn_s, b_sgn_s, div_done_s, div_start_s;

    assign div_start_s = accept_s && funct7[1] && funct3[2];

    alu_div #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start_s),
        .signed_op(~funct3[0]),
        .dividend (rs1),
        .divisor  (rs2),
        .done     (div_done_s),
        .quot     (div_quot_s),
        .rem      (div_rem_s)
    );

    // Both operands are extended to 2*XLEN so one unsigned multiply covers all signedness mixes.
    always_comb begin
        a_sgn_s   = (mop_q == 2'b01) || (mop_q == 2'b10);
        b_sgn_s   = (mop_q == 2'b01);
        prod_s    = {{XLEN{a_sgn_s & op_a_q[XLEN-1]}}, op_a_q}
                  * {{XLEN{b_sgn_s & op_b_q[XLEN-1]}}, op_b_q};
        mul_res_s = (mop_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        div_res_s = mop_q[1] ? div_rem_s : div_quot_s;
    end
`endif

    // Single-cycle base operations on the live inputs.
    always_comb begin
        base_res_s = {XLEN{1'b0}};
        base_c_s   = 1'b0;
        base_v_s   = 1'b0;
        b_op_s     = funct7[0] ? ~rs2 : rs2;
        sum_s      = {1'b0, rs1} + {1'b0, b_op_s} + {{XLEN{1'b0}}, funct7[0]};
        shamt_s    = rs2[SHW-1:0];
        sra_s      = $signed(rs1) >>> shamt_s;
        case (funct3)
            F3_ADD: begin
                base_res_s = sum_s[XLEN-1:0];
                base_c_s   = sum_s[XLEN];
                base_v_s   = (rs1[XLEN-1] == b_op_s[XLEN-1]) && (sum_s[XLEN-1] != rs1[XLEN-1]);
            end
            F3_SLL:  base_res_s = rs1 << shamt_s;
            F3_SLT:  base_res_s = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            F3_SLTU: base_res_s = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
            F3_XOR:  base_res_s = rs1 ^ rs2;
            F3_SR: begin
                if (funct7[0]) begin
                    base_res_s = sra_s;
                end else begin
                    base_res_s = rs1 >> shamt_s;
                end
            end
            F3_OR:   base_res_s = rs1 | rs2;
            F3_AND:  base_res_s = rs1 & rs2;
            default: base_res_s = {XLEN{1'b0}};
        endcase
    end

    // FSM next state and result/flag capture.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        v_d     = v_q;
        ill_d   = ill_q;
`ifdef ALU_M_EXT_EN
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        mop_d   = mop_q;
`endif
        if (accept_s) begin
            if (!funct7[1]) begin
                rd_d    = base_res_s;
                z_d     = (base_res_s == {XLEN{1'b0}});
                n_d     = base_res_s[XLEN-1];
                c_d     = base_c_s;
                v_d     = base_v_s;
                ill_d   = 1'b0;
                state_d = ST_DONE;
            end else begin
`ifdef ALU_M_EXT_EN
                op_a_d  = rs1;
                op_b_d  = rs2;
                mop_d   = funct3[1:0];
                state_d = funct3[2] ? ST_DIV : ST_MUL;
`else
                rd_d    = {XLEN{1'b0}};
                z_d     = 1'b0;
                n_d     = 1'b0;
                c_d     = 1'b0;
                v_d     = 1'b0;
                ill_d   = 1'b1;
                state_d = ST_DONE;
`endif
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
`ifdef ALU_M_EXT_EN
                ST_MUL: begin
                    rd_d    = mul_res_s;
                    z_d     = (mul_res_s == {XLEN{1'b0}});
                    n_d     = mul_res_s[XLEN-1];
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    ill_d   = 1'b0;
                    state_d = ST_DONE;
                end
                ST_DIV: begin
                    if (div_done_s) begin
                        rd_d    = div_res_s;
                        z_d     = (div_res_s == {XLEN{1'b0}});
                        n_d     = div_res_s[XLEN-1];
                        c_d     = 1'b0;
                        v_d     = 1'b0;
                        ill_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rd_q    <= {XLEN{1'b0}};
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            ill_q   <= 1'b0;
`ifdef ALU_M_EXT_EN
            op_a_q  <= {XLEN{1'b0}};
            op_b_q  <= {XLEN{1'b0}};
            mop_q   <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
            ill_q   <= ill_d;
`ifdef ALU_M_EXT_EN
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            mop_q   <= mop_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: vector table through a scoreboard plus
// hand-written backpressure, back-to-back and reset-abort sequences.
module tb_alu_mc;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [XLEN-1:0] rs1, rs2, rd;
    logic [2:0]      funct3;
    logic [1:0]      funct7;
    logic            z, n, c, v, illegal, busy;

    alu_mc #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd),
        .z(z), .n(n), .c(c), .v(v), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [1:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rd;
        logic [4:0]  fl;   // {z,n,c,v,illegal}
        int          lat;  // 0 = latency not checked
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic [4:0]  fl;
        int          lat;
        int          acc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add_v(input string nm, input logic [1:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                         input logic [4:0] fl, input int lat);
        vec_t t;
        t.name = nm; t.f7 = f7; t.f3 = f3; t.a = a; t.b = b; t.rd = r; t.fl = fl; t.lat = lat;
        vecs.push_back(t);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input vec_t t, output int acc);
        exp_t e;
        int   k;
        in_valid = 1'b1; funct7 = t.f7; funct3 = t.f3; rs1 = t.a; rs2 = t.b;
        acc = -1;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 100) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout %s: in_ready stayed 0 expected 1", t.name);
        end else begin
            acc = cyc + 1;
            e.name = t.name; e.rd = t.rd; e.fl = t.fl; e.lat = t.lat; e.acc = acc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs1 = $urandom; rs2 = $urandom;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: compare on every handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_out: got rd=%h expected no result", rd);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_rd"}, 64'(rd), 64'(mon_e.rd));
                chk({mon_e.name, "_flags"}, 64'({z, n, c, v, illegal}), 64'(mon_e.fl));
                if (mon_e.lat != 0)
                    chk({mon_e.name, "_lat"}, 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
            end
        end
    end

    initial begin
        int   acc, prev;
        vec_t t;

        add_v("add",     2'b00, 3'b000, 32'd20,        32'd30,        32'd50,        5'b00000, 1);
        add_v("sub_z",   2'b01, 3'b000, 32'd20,        32'd20,        32'd0,         5'b10100, 1);
        add_v("sub_ovf", 2'b01, 3'b000, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 5'b00110, 1);
        add_v("sra",     2'b01, 3'b101, 32'h8000_0000, 32'd4,         32'hF800_0000, 5'b01000, 1);
        add_v("sll35",   2'b00, 3'b001, 32'd1,         32'd35,        32'd8,         5'b00000, 1);
        add_v("srl",     2'b00, 3'b101, 32'h8000_0000, 32'd4,         32'h0800_0000, 5'b00000, 1);
        add_v("slt",     2'b00, 3'b010, 32'hFFFF_FFFF, 32'd1,         32'd1,         5'b00000, 1);
        add_v("sltu",    2'b00, 3'b011, 32'hFFFF_FFFF, 32'd1,         32'd0,         5'b10000, 1);
        add_v("xor",     2'b00, 3'b100, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 5'b00000, 1);
        add_v("or",      2'b00, 3'b110, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 5'b00000, 1);
        add_v("and",     2'b00, 3'b111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 5'b00000, 1);
        add_v("add_wrap",2'b00, 3'b000, 32'hFFFF_FFFF, 32'd1,         32'd0,         5'b10100, 1);
        add_v("add_ovf", 2'b00, 3'b000, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 5'b01010, 1);
`ifdef ALU_M_EXT_EN
        add_v("mulhu",   2'b10, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'b01000, 2);
        add_v("mul",     2'b10, 3'b000, 32'd3,         32'd4,         32'd12,        5'b00000, 2);
        add_v("mul_neg", 2'b10, 3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 5'b01000, 2);
        add_v("mulh",    2'b10, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         5'b10000, 2);
        add_v("mulhsu",  2'b10, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b01000, 2);
        add_v("div",     2'b10, 3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 5'b01000, 34);
        add_v("rem",     2'b10, 3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 5'b01000, 34);
        add_v("divu0",   2'b10, 3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'b01000, 34);
        add_v("rem0",    2'b10, 3'b110, 32'd5,         32'd0,         32'd5,         5'b00000, 34);
        add_v("div_ovf", 2'b10, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'b01000, 34);
        add_v("rem_ovf", 2'b10, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         5'b10000, 34);
        add_v("divu",    2'b10, 3'b101, 32'd100,       32'd7,         32'd14,        5'b00000, 34);
        add_v("remu",    2'b10, 3'b111, 32'd100,       32'd7,         32'd2,         5'b00000, 34);
        add_v("div_neg", 2'b10, 3'b100, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 5'b01000, 34);
`else
        add_v("mul_ill", 2'b10, 3'b000, 32'd3,         32'd4,         32'd0,         5'b00001, 1);
        add_v("div_ill", 2'b10, 3'b100, 32'hFFFF_FFF9, 32'd2,         32'd0,         5'b00001, 1);
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rs1 = 32'd0; rs2 = 32'd0; funct3 = 3'b000; funct7 = 2'b00;
        repeat (2) @(negedge clk);
        chk("in_reset_ctl", 64'({in_ready, out_valid, busy, z, n, c, v, illegal}), 64'(8'b1000_0000));
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ctl", 64'({in_ready, out_valid, busy, z, n, c, v, illegal}), 64'(8'b1000_0000));
        chk("reset_rd", 64'(rd), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i], acc);
            drain();
        end

        // Back-to-back base ops must be accepted on consecutive edges.
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            t.name = $sformatf("b2b%0d", i); t.f7 = 2'b00; t.f3 = 3'b000;
            t.a = 32'd100 * i; t.b = 32'd7; t.rd = 32'd100 * i + 32'd7;
            t.fl = 5'b00000; t.lat = 1;
            issue(t, acc);
            if (i > 0) chk($sformatf("b2b_gap%0d", i), 64'(acc - prev), 64'd1);
            prev = acc;
        end
        drain();

        // Backpressure: result held and no new acceptance.
        out_ready = 1'b0;
        t.name = "bp"; t.f7 = 2'b00; t.f3 = 3'b000; t.a = 32'd7; t.b = 32'd8;
        t.rd = 32'd15; t.fl = 5'b00000; t.lat = 0;
        issue(t, acc);
        in_valid = 1'b1; funct3 = 3'b100; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_ctl", 64'({out_valid, in_ready}), 64'(2'b10));
            chk("bp_hold_rd", 64'(rd), 64'd15);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        drain();

        // Reset in the middle of an operation aborts it.
`ifdef ALU_M_EXT_EN
        in_valid = 1'b1; funct7 = 2'b10; funct3 = 3'b100; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("div_busy", 64'(busy), 64'd1);
`else
        out_ready = 1'b0;
        in_valid = 1'b1; funct7 = 2'b00; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_abort_valid", 64'(out_valid), 64'd1);
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ctl", 64'({in_ready, out_valid, busy, z, n, c, v, illegal}), 64'(8'b1000_0000));
        chk("abort_rd", 64'(rd), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        t.name = "post_rst"; t.f7 = 2'b00; t.f3 = 3'b000; t.a = 32'd1; t.b = 32'd2;
        t.rd = 32'd3; t.fl = 5'b00000; t.lat = 1;
        issue(t, acc);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
